// File: rtl/binary_clock_core.sv
// Binary clock timekeeping core: one synchronous prescaler plus clock-enable
// seconds/minutes/hours counters, with auto-repeating set buttons and a seconds clear.

module binary_clock_core_btn #(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic evt_o
);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_o   = 1'b0;
      if (!btn_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == IDLE) begin
         if (!prev_q) begin
            evt_o   = 1'b1;
            cnt_d   = RW'(REPEAT_DELAY);
            state_d = HOLD;
         end
      end else if (cnt_q == RW'(1)) begin
         evt_o = 1'b1;
         cnt_d = RW'(REPEAT_PERIOD);
      end else begin
         cnt_d = cnt_q - RW'(1);
      end
   end

   // prev_q resets high so a button held through reset needs a fresh rising edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= btn_i;
      end
   end
endmodule

module binary_clock_core #(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned MODE_24H      = 1,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic       btn_min,
   input  logic       btn_hr,
   input  logic       btn_sec_clr,
   output logic       tick_1hz,
   output logic       blink,
   output logic [5:0] seconds,
   output logic [5:0] minute,
   output logic [4:0] hour,
   output logic       pm
);
   localparam int unsigned     PW       = $clog2(CLK_HZ);
   localparam logic [PW-1:0]   PSC_LAST = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]   PSC_HALF = PW'(CLK_HZ / 2);
   localparam logic [4:0]      HOUR_RST = (MODE_24H != 0) ? 5'd0 : 5'd12;

   logic [PW-1:0] psc_q, psc_d;
   logic          tick_q, tick_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          pm_q, pm_d;
   logic          min_carry, hr_carry, min_evt, hr_evt;
   logic [6:0]    min_sum;
   logic [5:0]    hr_sum;

   function automatic logic [5:0] step12(input logic [4:0] h, input logic p);
      logic [4:0] hn;
      logic       pn;
      hn = (h == 5'd12) ? 5'd1 : h + 5'd1;
      pn = (h == 5'd11) ? ~p : p;
      return {pn, hn};
   endfunction

   binary_clock_core_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_btn_min (
      .clk_i(clk_100MHz), .rst_ni(rst_n), .btn_i(btn_min), .evt_o(min_evt));

   binary_clock_core_btn #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_btn_hr (
      .clk_i(clk_100MHz), .rst_ni(rst_n), .btn_i(btn_hr), .evt_o(hr_evt));

   always_comb begin
      psc_d     = (psc_q == PSC_LAST) ? '0 : psc_q + PW'(1);
      tick_d    = (psc_q == PSC_LAST);
      sec_d     = sec_q;
      min_carry = 1'b0;
      if (btn_sec_clr) begin
         psc_d  = '0;
         tick_d = 1'b0;
         sec_d  = '0;
      end else if (tick_q) begin
         if (sec_q == 6'd59) begin
            sec_d     = '0;
            min_carry = 1'b1;
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   always_comb begin
      min_sum  = {1'b0, min_q} + {6'd0, min_carry} + {6'd0, min_evt};
      min_d    = (min_sum >= 7'd60) ? 6'(min_sum - 7'd60) : min_sum[5:0];
      hr_carry = min_carry && (min_q == 6'd59);
      hr_sum   = '0;
      hour_d   = hour_q;
      pm_d     = pm_q;
      if (MODE_24H != 0) begin
         hr_sum = {1'b0, hour_q} + {5'd0, hr_carry} + {5'd0, hr_evt};
         hour_d = (hr_sum >= 6'd24) ? 5'(hr_sum - 6'd24) : hr_sum[4:0];
         pm_d   = 1'b0;
      end else begin
         // a coincident carry and event are two successive single steps, so pm sees each 11->12
         if (hr_carry) {pm_d, hour_d} = step12(hour_d, pm_d);
         if (hr_evt)   {pm_d, hour_d} = step12(hour_d, pm_d);
      end
   end

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         psc_q  <= '0;
         tick_q <= 1'b0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= HOUR_RST;
         pm_q   <= 1'b0;
      end else begin
         psc_q  <= psc_d;
         tick_q <= tick_d;
         sec_q  <= sec_d;
         min_q  <= min_d;
         hour_q <= hour_d;
         pm_q   <= pm_d;
      end
   end

   assign tick_1hz = tick_q;
   assign blink    = (psc_q < PSC_HALF);
   assign seconds  = sec_q;
   assign minute   = min_q;
   assign hour     = hour_q;
   assign pm       = pm_q;
endmodule
